// File: rtl/claw_loot_ctrl.sv
// claw_loot_ctrl: latches the loot item the claw grabs, drives the retract
// speed from the item's kind, and awards its score when the claw returns.
// Optional feature macro: CLAW_LOOT_RELEASE_EN (adds release_req, which lets
// the claw drop the carried item without scoring).
// Handshake note: there is no valid/ready pair here; score_pulse is a
// one-clock strobe that qualifies score_add, and all outputs are registered.
module claw_loot_ctrl #(
   parameter int NUM_LOOT   = 8,
   parameter int BASE_SPEED = 4
) (
   input  logic                  clk,
   input  logic                  resetN,
   input  logic                  startOfFrame,
   input  logic                  start_level,
   input  logic                  claw_collision,
   input  logic [NUM_LOOT-1:0]   hit_vec,
   input  logic [2*NUM_LOOT-1:0] loot_kind,
   input  logic                  claw_returned,
`ifdef CLAW_LOOT_RELEASE_EN
   input  logic                  release_req,
`endif
   output logic [3:0]            move_speed,
   output logic                  carry_valid,
   output logic [2:0]            carry_idx,
   output logic [1:0]            carry_kind,
   output logic [NUM_LOOT-1:0]   loot_alive,
   output logic [9:0]            score_add,
   output logic                  score_pulse,
   output logic                  level_cleared,
   output logic [1:0]            state_dbg
);

   typedef enum logic [1:0] {
      S_EMPTY   = 2'd0,
      S_CAPTURE = 2'd1,
      S_CARRY   = 2'd2,
      S_DELIVER = 2'd3
   } state_t;

   localparam logic [3:0] BASE_SPD = 4'(BASE_SPEED);

   state_t                state, state_d;
   logic                  armed, armed_d;
   logic [3:0]            speed_d;
   logic                  valid_d, pulse_d, cleared_d;
   logic [2:0]            idx_d, pick_idx;
   logic [1:0]            kind_d, pick_kind;
   logic [NUM_LOOT-1:0]   alive_d, cand;
   logic [9:0]            add_d;

   // Retract speed per loot kind; small gold shares the empty-claw speed.
   function automatic logic [3:0] kind_speed(input logic [1:0] k);
      case (k)
         2'd0:    return BASE_SPD;
         2'd1:    return 4'd2;
         2'd2:    return 4'd1;
         default: return 4'd8;
      endcase
   endfunction

   // Points awarded per loot kind.
   function automatic logic [9:0] kind_score(input logic [1:0] k);
      case (k)
         2'd0:    return 10'd50;
         2'd1:    return 10'd250;
         2'd2:    return 10'd10;
         default: return 10'd500;
      endcase
   endfunction

   assign state_dbg = state;

   // Lowest-index alive slot under the claw, and its kind.
   always_comb begin
      cand      = hit_vec & loot_alive;
      pick_idx  = '0;
      pick_kind = '0;
      for (int i = NUM_LOOT - 1; i >= 0; i--) begin
         if (cand[i]) begin
            pick_idx  = 3'(i);
            pick_kind = loot_kind[2*i +: 2];
         end
      end
   end

   // Next state and next registered output values; start_level overrides all.
   always_comb begin
      state_d = state;
      armed_d = armed | startOfFrame;
      speed_d = move_speed;
      valid_d = carry_valid;
      idx_d   = carry_idx;
      kind_d  = carry_kind;
      alive_d = loot_alive;
      add_d   = score_add;
      pulse_d = 1'b0;
      case (state)
         S_EMPTY: begin
            speed_d = BASE_SPD;
            if (armed && claw_collision && (|cand)) begin
               idx_d   = pick_idx;
               kind_d  = pick_kind;
               state_d = S_CAPTURE;
            end
         end
         S_CAPTURE: begin
            for (int i = 0; i < NUM_LOOT; i++) begin
               if (32'(carry_idx) == i) alive_d[i] = 1'b0;
            end
            valid_d = 1'b1;
            speed_d = kind_speed(carry_kind);
            state_d = S_CARRY;
         end
         S_CARRY: begin
`ifdef CLAW_LOOT_RELEASE_EN
            if (release_req) begin
               valid_d = 1'b0;
               speed_d = BASE_SPD;
               state_d = S_EMPTY;
            end else if (claw_returned) begin
               state_d = S_DELIVER;
            end
`else
            if (claw_returned) state_d = S_DELIVER;
`endif
         end
         default: begin
            // Claw still overlaps loot at the pivot: hold off re-grab until
            // the next frame boundary.
            pulse_d = 1'b1;
            add_d   = kind_score(carry_kind);
            valid_d = 1'b0;
            speed_d = BASE_SPD;
            armed_d = 1'b0;
            state_d = S_EMPTY;
         end
      endcase
      if (start_level) begin
         state_d = S_EMPTY;
         alive_d = '1;
         valid_d = 1'b0;
         speed_d = BASE_SPD;
         pulse_d = 1'b0;
         armed_d = 1'b1;
      end
      cleared_d = ~valid_d;
      for (int i = 0; i < NUM_LOOT; i++) begin
         if (alive_d[i] && (loot_kind[2*i +: 2] != 2'd2)) cleared_d = 1'b0;
      end
   end

   // State register.
   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) state <= S_EMPTY;
      else         state <= state_d;
   end

   // Registered outputs and re-arm flag.
   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         armed         <= 1'b1;
         move_speed    <= BASE_SPD;
         carry_valid   <= 1'b0;
         carry_idx     <= '0;
         carry_kind    <= '0;
         loot_alive    <= '1;
         score_add     <= '0;
         score_pulse   <= 1'b0;
         level_cleared <= 1'b0;
      end else begin
         armed         <= armed_d;
         move_speed    <= speed_d;
         carry_valid   <= valid_d;
         carry_idx     <= idx_d;
         carry_kind    <= kind_d;
         loot_alive    <= alive_d;
         score_add     <= add_d;
         score_pulse   <= pulse_d;
         level_cleared <= cleared_d;
      end
   end

endmodule
